// File: rtl/vc_fifo_buffer.sv
// Multi-virtual-channel flit buffer: V independent FIFOs of depth B sharing one
// V*B-entry read-first RAM, with an optional empty-VC write-to-read bypass.
module vc_fifo_buffer #(
  parameter int    V          = 4,
  parameter int    B          = 4,
  parameter int    DATA_WIDTH = 32,
  parameter string SSA_EN     = "YES"
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_wr_en,
  input  logic [V-1:0]          i_vc_num_wr,
  input  logic                  i_rd_en,
  input  logic [V-1:0]          i_vc_num_rd,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_dout_valid,
  output logic [V-1:0]          o_vc_not_empty,
  output logic [V-1:0]          o_vc_full,
  output logic                  o_err
);

  localparam int PTR_W  = $clog2(B);
  localparam int CNT_W  = PTR_W + 1;
  localparam int VC_W   = $clog2(V);
  localparam int ADDR_W = VC_W + PTR_W;
  localparam int DEPTH  = V * B;
  localparam bit SSA    = (SSA_EN == "YES");

  function automatic logic [VC_W-1:0] vc_enc(input logic [V-1:0] sel);
    logic [VC_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < V; i++) begin
      if (sel[i]) idx = VC_W'(i);
    end
    return idx;
  endfunction

  logic [CNT_W-1:0]      r_cnt    [V];
  logic [PTR_W-1:0]      r_wr_ptr [V];
  logic [PTR_W-1:0]      r_rd_ptr [V];
  logic [DATA_WIDTH-1:0] r_mem    [DEPTH];

  logic [DATA_WIDTH-1:0] r_dout_p1;
  logic                  r_vld_p1;
  logic [V-1:0]          r_not_empty;
  logic [V-1:0]          r_full;
  logic                  r_err;

  logic                  w_wr_oh;
  logic                  w_rd_oh;
  logic [VC_W-1:0]       w_wr_idx;
  logic [VC_W-1:0]       w_rd_idx;
  logic                  w_wr_full;
  logic                  w_rd_empty;
  logic                  w_same;
  logic                  w_bypass;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_err_set;
  logic [ADDR_W-1:0]     w_wr_addr;
  logic [ADDR_W-1:0]     w_rd_addr;
  logic [CNT_W-1:0]      w_cnt_nxt [V];

  assign w_wr_oh    = $onehot(i_vc_num_wr);
  assign w_rd_oh    = $onehot(i_vc_num_rd);
  assign w_wr_idx   = vc_enc(i_vc_num_wr);
  assign w_rd_idx   = vc_enc(i_vc_num_rd);
  assign w_wr_full  = (r_cnt[w_wr_idx] == CNT_W'(B));
  assign w_rd_empty = (r_cnt[w_rd_idx] == '0);
  assign w_same     = (i_vc_num_wr == i_vc_num_rd);

  // A full VC still accepts a write when the same VC is drained this cycle.
  assign w_bypass  = SSA && i_wr_en && i_rd_en && w_wr_oh && w_rd_oh && w_same && w_rd_empty;
  assign w_rd_ok   = i_rd_en && w_rd_oh && !w_rd_empty;
  assign w_wr_ok   = i_wr_en && w_wr_oh && !w_bypass && (!w_wr_full || (w_rd_ok && w_same));
  assign w_err_set = (i_wr_en && !w_wr_ok && !w_bypass) || (i_rd_en && !w_rd_ok && !w_bypass);

  assign w_wr_addr = {w_wr_idx, r_wr_ptr[w_wr_idx]};
  assign w_rd_addr = {w_rd_idx, r_rd_ptr[w_rd_idx]};

  always_comb begin
    for (int v = 0; v < V; v++) begin
      w_cnt_nxt[v] = r_cnt[v];
      if (w_wr_ok && (w_wr_idx == VC_W'(v)) && !(w_rd_ok && (w_rd_idx == VC_W'(v))))
        w_cnt_nxt[v] = r_cnt[v] + CNT_W'(1);
      else if (w_rd_ok && (w_rd_idx == VC_W'(v)) && !(w_wr_ok && (w_wr_idx == VC_W'(v))))
        w_cnt_nxt[v] = r_cnt[v] - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[w_wr_addr] <= i_din;
  end

  // Stage p1: registered read data, valid and per-VC status
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int v = 0; v < V; v++) begin
        r_cnt[v]    <= '0;
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
      end
      r_dout_p1   <= '0;
      r_vld_p1    <= 1'b0;
      r_not_empty <= '0;
      r_full      <= '0;
      r_err       <= 1'b0;
    end else begin
      for (int v = 0; v < V; v++) begin
        r_cnt[v]       <= w_cnt_nxt[v];
        r_not_empty[v] <= (w_cnt_nxt[v] != '0);
        r_full[v]      <= (w_cnt_nxt[v] == CNT_W'(B));
        if (w_wr_ok && (w_wr_idx == VC_W'(v))) r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
        if (w_rd_ok && (w_rd_idx == VC_W'(v))) r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
      end
      r_vld_p1 <= w_bypass || w_rd_ok;
      if (w_bypass)     r_dout_p1 <= i_din;
      else if (w_rd_ok) r_dout_p1 <= r_mem[w_rd_addr];
      if (w_err_set)    r_err <= 1'b1;
    end
  end

  assign o_dout         = r_dout_p1;
  assign o_dout_valid   = r_vld_p1;
  assign o_vc_not_empty = r_not_empty;
  assign o_vc_full      = r_full;
  assign o_err          = r_err;

endmodule

// File: tb/tb_vc_fifo_buffer.sv
// Bench for vc_fifo_buffer: a bypass-enabled and a bypass-disabled instance share
// one stimulus stream and are each compared against a per-VC queue model.
module tb_vc_fifo_buffer;
  localparam int V  = 4;
  localparam int B  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          we  = 1'b0;
  logic          re  = 1'b0;
  logic [V-1:0]  ws  = '0;
  logic [V-1:0]  rs  = '0;

  logic [DW-1:0] y_dout, n_dout;
  logic          y_vld, n_vld, y_err, n_err;
  logic [V-1:0]  y_ne, n_ne, y_full, n_full;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq [2][V][$];
  logic          m_err  [2];
  logic [DW-1:0] m_dout [2];
  logic          m_vld  [2];

  always #5 clk = ~clk;

  vc_fifo_buffer #(.V(V), .B(B), .DATA_WIDTH(DW), .SSA_EN("YES")) u_yes (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_wr_en(we), .i_vc_num_wr(ws),
    .i_rd_en(re), .i_vc_num_rd(rs), .o_dout(y_dout), .o_dout_valid(y_vld),
    .o_vc_not_empty(y_ne), .o_vc_full(y_full), .o_err(y_err));

  vc_fifo_buffer #(.V(V), .B(B), .DATA_WIDTH(DW), .SSA_EN("NO")) u_no (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_wr_en(we), .i_vc_num_wr(ws),
    .i_rd_en(re), .i_vc_num_rd(rs), .o_dout(n_dout), .o_dout_valid(n_vld),
    .o_vc_not_empty(n_ne), .o_vc_full(n_full), .o_err(n_err));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [V-1:0] s);
    for (int i = 0; i < V; i++) if (s[i]) return i;
    return 0;
  endfunction

  // Instance m=0 has the bypass, m=1 does not.
  task automatic model_step(input int m, input logic w, input logic [V-1:0] wsel,
                            input logic [DW-1:0] d, input logic r, input logic [V-1:0] rsel);
    bit ssa = (m == 0);
    bit woh = ($countones(wsel) == 1);
    bit roh = ($countones(rsel) == 1);
    int wi  = idx_of(wsel);
    int ri  = idx_of(rsel);
    int wsz = mq[m][wi].size();
    int rsz = mq[m][ri].size();
    bit byp = ssa && w && r && woh && roh && (wi == ri) && (rsz == 0);
    bit rok = r && roh && (rsz > 0);
    bit wok = w && woh && !byp && ((wsz < B) || (rok && wi == ri));
    if ((w && !wok && !byp) || (r && !rok && !byp)) m_err[m] = 1'b1;
    m_vld[m] = byp || rok;
    if (byp)      m_dout[m] = d;
    else if (rok) m_dout[m] = mq[m][ri].pop_front();
    if (wok)      mq[m][wi].push_back(d);
  endtask

  task automatic check_all(input string tag);
    logic [V-1:0] ene, efu;
    for (int m = 0; m < 2; m++) begin
      string s = (m == 0) ? "yes" : "no";
      for (int v = 0; v < V; v++) begin
        ene[v] = (mq[m][v].size() != 0);
        efu[v] = (mq[m][v].size() == B);
      end
      chk($sformatf("%s_%s_dout", tag, s), (m == 0) ? y_dout : n_dout, m_dout[m]);
      chk($sformatf("%s_%s_vld", tag, s), DW'((m == 0) ? y_vld : n_vld), DW'(m_vld[m]));
      chk($sformatf("%s_%s_ne", tag, s), DW'((m == 0) ? y_ne : n_ne), DW'(ene));
      chk($sformatf("%s_%s_full", tag, s), DW'((m == 0) ? y_full : n_full), DW'(efu));
      chk($sformatf("%s_%s_err", tag, s), DW'((m == 0) ? y_err : n_err), DW'(m_err[m]));
    end
  endtask

  task automatic cyc(input string tag, input logic w, input logic [V-1:0] wsel,
                     input logic [DW-1:0] d, input logic r, input logic [V-1:0] rsel);
    @(negedge clk);
    we = w; ws = wsel; din = d; re = r; rs = rsel;
    model_step(0, w, wsel, d, r, rsel);
    model_step(1, w, wsel, d, r, rsel);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Reset is raised between clock edges and its effect checked before the next edge.
  task automatic do_reset(input string tag);
    #1;
    we = 1'b0; re = 1'b0; ws = '0; rs = '0; din = '0;
    rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < V; v++) mq[m][v].delete();
      m_err[m] = 1'b0; m_dout[m] = '0; m_vld[m] = 1'b0;
    end
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] a [4];
    int rv, wv;
    logic w, r;
    logic [V-1:0] wsel, rsel;
    a[0] = 32'hA0; a[1] = 32'hA1; a[2] = 32'hA2; a[3] = 32'hA3;

    do_reset("rst0");

    // VC0 alone: fill, overflow, drain
    for (int i = 0; i < 4; i++) cyc("fill0", 1'b1, 4'b0001, a[i], 1'b0, 4'b0000);
    chk("fill0_full", DW'(y_full[0]), DW'(1));
    cyc("ovf0", 1'b1, 4'b0001, 32'hDEAD, 1'b0, 4'b0000);
    chk("ovf0_err", DW'(y_err), DW'(1));
    for (int i = 0; i < 4; i++) begin
      cyc("drain0", 1'b0, 4'b0000, '0, 1'b1, 4'b0001);
      chk("drain0_dout", y_dout, a[i]);
    end
    cyc("idle0", 1'b0, 4'b0000, '0, 1'b0, 4'b0000);
    chk("idle0_ne", DW'(y_ne[0]), DW'(0));

    // Interleaved VCs
    do_reset("rst1");
    cyc("pre3", 1'b1, 4'b1000, 32'h33, 1'b0, 4'b0000);
    cyc("il_a", 1'b1, 4'b0010, 32'h11, 1'b1, 4'b1000);
    chk("il_dout", y_dout, 32'h33);
    cyc("il_b", 1'b1, 4'b0100, 32'h22, 1'b0, 4'b0000);
    chk("il_ne", DW'(y_ne), DW'(4'b0110));
    chk("il_err", DW'(y_err), DW'(0));

    // Full VC2 with same-VC read and write, then pointer wrap on VC1
    do_reset("rst2");
    for (int i = 0; i < 4; i++) cyc("fill2", 1'b1, 4'b0100, 32'hC0 + i, 1'b0, 4'b0000);
    cyc("rw2", 1'b1, 4'b0100, 32'hFF, 1'b1, 4'b0100);
    chk("rw2_dout", y_dout, 32'hC0);
    chk("rw2_full", DW'(y_full[2]), DW'(1));
    for (int i = 0; i < 4; i++) cyc("drain2", 1'b0, 4'b0000, '0, 1'b1, 4'b0100);
    chk("drain2_last", y_dout, 32'hFF);
    cyc("wrap_w", 1'b1, 4'b0010, 32'h100, 1'b0, 4'b0000);
    for (int i = 1; i < 3 * B; i++) cyc("wrap_rw", 1'b1, 4'b0010, 32'h100 + i, 1'b1, 4'b0010);
    cyc("wrap_r", 1'b0, 4'b0000, '0, 1'b1, 4'b0010);
    chk("wrap_last", y_dout, 32'h100 + 3 * B - 1);

    // Bypass on empty VC0
    do_reset("rst3");
    cyc("byp", 1'b1, 4'b0001, 32'hAB, 1'b1, 4'b0001);
    chk("byp_yes_dout", y_dout, 32'hAB);
    chk("byp_yes_ne", DW'(y_ne[0]), DW'(0));
    chk("byp_no_err", DW'(n_err), DW'(1));
    chk("byp_no_ne", DW'(n_ne[0]), DW'(1));
    cyc("byp_rd", 1'b0, 4'b0000, '0, 1'b1, 4'b0001);
    chk("byp_no_dout", n_dout, 32'hAB);

    // Select checks
    do_reset("rst4");
    cyc("sel_mh", 1'b1, 4'b0011, 32'h55, 1'b0, 4'b0000);
    chk("sel_mh_err", DW'(y_err), DW'(1));
    chk("sel_mh_ne", DW'(y_ne), DW'(0));
    do_reset("rst5");
    cyc("sel_empty", 1'b0, 4'b0000, '0, 1'b1, 4'b0010);
    chk("sel_empty_err", DW'(y_err), DW'(1));
    chk("sel_empty_vld", DW'(y_vld), DW'(0));

    // Reset mid-stream with VC0 holding two flits
    do_reset("rst6");
    cyc("mid_w0", 1'b1, 4'b0001, 32'h77, 1'b0, 4'b0000);
    cyc("mid_w1", 1'b1, 4'b0001, 32'h78, 1'b1, 4'b0010);
    do_reset("mid_rst");
    chk("mid_rst_dout", y_dout, '0);
    cyc("mid_rd", 1'b0, 4'b0000, '0, 1'b1, 4'b0001);
    chk("mid_rd_vld", DW'(y_vld), DW'(0));
    chk("mid_rd_err", DW'(y_err), DW'(1));

    // Random legal traffic: never reads an empty VC, never overfills
    do_reset("rst7");
    for (int i = 0; i < 300; i++) begin
      rv = $urandom_range(0, V - 1);
      wv = $urandom_range(0, V - 1);
      r  = ($urandom_range(0, 1) == 1) && (mq[0][rv].size() > 0);
      w  = ($urandom_range(0, 1) == 1) && ((mq[0][wv].size() < B) || (r && rv == wv));
      cyc("rnd_legal", w, V'(1) << wv, $urandom, r, V'(1) << rv);
    end
    chk("rnd_legal_err", DW'(y_err), DW'(0));

    // Random unrestricted traffic including bad selects and bypasses
    do_reset("rst8");
    for (int i = 0; i < 200; i++) begin
      wsel = ($urandom_range(0, 9) == 0) ? V'($urandom) : (V'(1) << $urandom_range(0, V - 1));
      rsel = ($urandom_range(0, 9) == 0) ? V'($urandom) : (V'(1) << $urandom_range(0, V - 1));
      w = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 2) == 0);
      cyc("rnd_any", w, wsel, $urandom, r, rsel);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
